// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1 - 8N1 UART receiver for the processor serial port.
//
// Synchronises rxd, finds the start bit on a falling edge, samples eight data
// bits LSB-first at bit centres, checks the stop bit, and hands each good byte
// to the bus side through a holding register with a valid/ack handshake.
//
// Ports:
//   rst         in   async active-low reset
//   clk         in   system clock, rising edge
//   rxd         in   serial line, idle high, asynchronous to clk
//   rx_ack      in   consumer acknowledge, clears rx_valid and rx_overrun
//   rx_data     out  last good received byte
//   rx_valid    out  rx_data holds an unread byte
//   rx_overrun  out  sticky, a byte landed while rx_valid was still set
//   frame_err   out  one-cycle pulse when the stop bit is sampled low
//   busy        out  receiver is not idle
//
// State table:
//   state    | meaning
//   ST_IDLE  | line idle, watching for a falling edge on the synchronised line
//   ST_START | waiting half a bit to re-check the start bit at its centre
//   ST_DATA  | sampling the eight data bits, one per bit period
//   ST_STOP  | waiting for the stop bit centre, then deliver byte or flag error
//   ST_BREAK | stop bit was low, wait for the line to return high

module uart_rx_8n1 #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_overrun,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        s1;
    logic        s2;
    logic        s_prev;

    logic [15:0] timer;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift_reg;

    logic        expired;
    logic        load_half;
    logic        load_full;
    logic        bit_cnt_load;
    logic        shift_en;
    logic        byte_done;
    logic        stop_fail;

    // Synchroniser and edge history reset high so a line held low through
    // reset release is only seen as a start once s2 actually falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            s_prev <= 1'b1;
        end else begin
            s1     <= rxd;
            s2     <= s1;
            s_prev <= s2;
        end
    end

    assign expired = (timer == 16'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        load_half    = 1'b0;
        load_full    = 1'b0;
        bit_cnt_load = 1'b0;
        shift_en     = 1'b0;
        byte_done    = 1'b0;
        stop_fail    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s_prev && !s2) begin
                    load_half  = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (expired) begin
                    if (!s2) begin
                        load_full    = 1'b1;
                        bit_cnt_load = 1'b1;
                        state_next   = ST_DATA;
                    end else begin
                        // line came back high at the start centre: a glitch
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (expired) begin
                    shift_en  = 1'b1;
                    load_full = 1'b1;
                    if (bit_cnt == 4'd0) begin
                        state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (expired) begin
                    if (s2) begin
                        byte_done  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        stop_fail  = 1'b1;
                        state_next = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (s2) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Bit timer: parks at zero in IDLE and BREAK, where it is not consulted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= 16'd0;
        end else if (load_half) begin
            timer <= HALF_LOAD;
        end else if (load_full) begin
            timer <= FULL_LOAD;
        end else if (!expired) begin
            timer <= timer - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= 4'd0;
        end else if (bit_cnt_load) begin
            bit_cnt <= 4'd7;
        end else if (shift_en && (bit_cnt != 4'd0)) begin
            bit_cnt <= bit_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= 8'h00;
        end else if (shift_en) begin
            shift_reg <= {s2, shift_reg[7:1]};
        end
    end

    // Holding register and handshake. A byte completing in the same cycle as
    // rx_ack counts as the ack consuming the old byte, so no overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else if (byte_done) begin
            rx_data  <= shift_reg;
            rx_valid <= 1'b1;
            if (rx_ack) begin
                rx_overrun <= 1'b0;
            end else if (rx_valid) begin
                rx_overrun <= 1'b1;
            end
        end else if (rx_ack) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= stop_fail;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1 - directed bench for uart_rx_8n1 with CLKS_PER_BIT=16.
//
// Frames are driven one bit period (16 clocks) per bit, with rxd changed 1
// time unit after a rising edge. Taking P0 as the rising edge just before rxd
// falls, the stop bit is sampled at P155 (9.5 bit periods + 3 cycles), so all
// checks are placed relative to that edge.

module tb_uart_rx_8n1;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_overrun;
    logic       frame_err;
    logic       busy;

    int n_asserts = 0;
    int n_fail    = 0;
    int ferr_cnt  = 0;
    int f0;

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
        .rst        (rst),
        .clk        (clk),
        .rxd        (rxd),
        .rx_ack     (rx_ack),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_overrun (rx_overrun),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) ferr_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        tick(CPB);
    endtask

    // Start bit plus eight data bits; leaves rxd at the stop level at P144+1.
    task automatic send_head(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        rxd = stop;
    endtask

    // Complete good frame; returns at P160+1 with the line idle.
    task automatic send_frame(input logic [7:0] d);
        send_head(d, 1'b1);
        tick(CPB);
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
    endtask

    initial begin
        // reset state
        rst = 1'b0;
        rxd = 1'b1;
        tick(3);
        check("rst_data",    rx_data,    8'h00);
        check("rst_valid",   rx_valid,   1'b0);
        check("rst_overrun", rx_overrun, 1'b0);
        check("rst_ferr",    frame_err,  1'b0);
        check("rst_busy",    busy,       1'b0);
        rst = 1'b1;
        tick(5);

        // 0xA5, valid exactly at the stop sample, ack drops it next cycle
        send_head(8'hA5, 1'b1);
        check("a5_busy", busy, 1'b1);
        tick(10);
        check("a5_valid_early", rx_valid, 1'b0);
        tick(1);
        check("a5_valid", rx_valid,  1'b1);
        check("a5_data",  rx_data,   8'hA5);
        check("a5_ferr",  frame_err, 1'b0);
        check("a5_idle",  busy,      1'b0);
        tick(5);
        pulse_ack();
        check("a5_ack_valid", rx_valid, 1'b0);

        // back-to-back 0x3C, 0xFF without ack -> overrun
        send_frame(8'h3C);
        check("3c_data",    rx_data,    8'h3C);
        check("3c_valid",   rx_valid,   1'b1);
        check("3c_overrun", rx_overrun, 1'b0);
        send_frame(8'hFF);
        check("ff_data",    rx_data,    8'hFF);
        check("ff_valid",   rx_valid,   1'b1);
        check("ff_overrun", rx_overrun, 1'b1);
        pulse_ack();
        check("ovr_ack_valid",   rx_valid,   1'b0);
        check("ovr_ack_overrun", rx_overrun, 1'b0);
        pulse_ack();
        check("idle_ack_valid",   rx_valid,   1'b0);
        check("idle_ack_overrun", rx_overrun, 1'b0);

        // 0x55 with low stop bit, line held low 3 bit periods, then 0x12
        f0 = ferr_cnt;
        send_head(8'h55, 1'b0);
        tick(10);
        check("55_ferr_early", frame_err, 1'b0);
        tick(1);
        check("55_ferr",  frame_err, 1'b1);
        check("55_valid", rx_valid,  1'b0);
        tick(1);
        check("55_ferr_end",   frame_err, 1'b0);
        check("55_break_busy", busy,      1'b1);
        tick(4 + 3 * CPB);
        check("break_busy",   busy,                1'b1);
        check("break_valid",  rx_valid,            1'b0);
        check("break_ferr_n", 8'(ferr_cnt - f0),   8'd1);
        rxd = 1'b1;
        tick(CPB);
        check("break_exit", busy, 1'b0);
        send_frame(8'h12);
        check("12_data",   rx_data,            8'h12);
        check("12_valid",  rx_valid,           1'b1);
        check("12_ferr_n", 8'(ferr_cnt - f0),  8'd1);

        // 4-cycle glitch on idle line
        pulse_ack();
        tick(2);
        f0 = ferr_cnt;
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        check("glitch_start", busy, 1'b1);
        tick(7);
        check("glitch_abort", busy, 1'b0);
        tick(2 * CPB);
        check("glitch_valid",  rx_valid,           1'b0);
        check("glitch_ferr_n", 8'(ferr_cnt - f0),  8'd0);
        check("glitch_idle",   busy,               1'b0);

        // reset during bit 4 of 0x81, then 0x7E
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rxd = 1'b0;
        tick(8);
        check("81_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_rst_data",    rx_data,    8'h00);
        check("mid_rst_valid",   rx_valid,   1'b0);
        check("mid_rst_overrun", rx_overrun, 1'b0);
        check("mid_rst_ferr",    frame_err,  1'b0);
        check("mid_rst_busy",    busy,       1'b0);
        rxd = 1'b1;
        tick(3);
        rst = 1'b1;
        f0 = ferr_cnt;
        tick(2 * CPB);
        check("post_rst_idle", busy, 1'b0);
        send_frame(8'h7E);
        check("7e_data",    rx_data,           8'h7E);
        check("7e_valid",   rx_valid,          1'b1);
        check("7e_overrun", rx_overrun,        1'b0);
        check("7e_ferr_n",  8'(ferr_cnt - f0), 8'd0);

        // ack in the same cycle 0x99 completes, rx_valid already set
        send_head(8'h99, 1'b1);
        tick(10);
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        check("99_data",    rx_data,    8'h99);
        check("99_valid",   rx_valid,   1'b1);
        check("99_overrun", rx_overrun, 1'b0);
        tick(5);
        pulse_ack();
        check("99_ack_valid", rx_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_8n1.md
# uart_rx_8n1

UART receiver for the processor's serial port, the receive-side counterpart of the existing transmit path. Synchronises the asynchronous `rxd` line, detects a start bit, samples 8 data bits LSB-first at bit centres, checks the stop bit, and presents each good byte in a holding register with a valid/acknowledge handshake to the bus-side UART register logic. Reports framing errors and overruns.

## Interface
- `CLKS_PER_BIT`, 868, clk cycles per bit period (100 MHz / 115200); legal range 8..65535.
- `rst`  in  1  asynchronous, active-low reset.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rxd`  in  1  serial input, idle high, asynchronous to `clk`.
- `rx_ack`  in  1  consumer acknowledge; clears `rx_valid` and `rx_overrun`.
- `rx_data`  out  8  last good received byte.
- `rx_valid`  out  1  `rx_data` holds an unread byte.
- `rx_overrun`  out  1  sticky: a byte completed while `rx_valid` was already high.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Input path: 2-FF synchroniser (`s1`, `s2`) plus a previous-value register `s_prev`, all reset to 1.
- Bit timer: 16-bit down counter; loaded on state entry, decrements each cycle, and expires when it reaches 0.
- Bit counter: 4-bit down counter, loaded with 7 on DATA entry and decremented per data sample. Reaching 0 with a sample ends DATA.
- States:
  - IDLE: on `s_prev`=1 and `s2`=0, load timer with CLKS_PER_BIT/2 − 1 and go to START.
  - START: on timer expiry, sample `s2`. If 0, load timer with CLKS_PER_BIT − 1 and go to DATA. If 1, treat it as a glitch and return to IDLE with no flags.
  - DATA: on each expiry, shift `s2` into bit 7 of the shift register (right shift, LSB-first) and reload the timer. After the 8th sample, go to STOP.
  - STOP: on expiry, sample `s2`.
    - If 1: `rx_data` ← shift register; `rx_valid` ← 1; if `rx_valid` was already 1 and `rx_ack` is not asserted in the same cycle, set `rx_overrun`. Go to IDLE.
    - If 0: pulse `frame_err`, leave `rx_data`/`rx_valid` unchanged, go to BREAK.
  - BREAK: wait for `s2`=1, then go to IDLE. This prevents a held-low line from generating repeated start detections.
- Handshake: `rx_ack` high for one cycle clears `rx_valid` and `rx_overrun` on the next edge.
  - Simultaneous `rx_ack` and byte completion: the new byte is loaded, `rx_valid` stays 1, and `rx_overrun` is not set.
  - `rx_ack` while `rx_valid`=0 has no effect.
- Overrun: the new byte overwrites `rx_data`; the older byte is lost.
- Reset values: `rx_data`=0x00, `rx_valid`=0, `rx_overrun`=0, `frame_err`=0, `busy`=0, state IDLE, timer 0, bit counter 0, shift register 0.
- Reset mid-frame aborts immediately. After release, the receiver resumes in IDLE and waits for the next falling edge. If `rxd` is low at release, that is not a falling edge: `s_prev` resets to 1, so a start is detected only once `s2` goes low after release.

## Timing
- Synchroniser latency: 2 cycles from an `rxd` change to `s2`.
- The start edge is detected in the cycle where `s2` first reads 0; START is entered on the following edge.
- Sample points fall at CLKS_PER_BIT/2 after the detected edge, then every CLKS_PER_BIT (bit centres, ±1 cycle quantisation).
- `rx_valid` rises on the clock edge at which the stop bit is sampled, about 9.5 bit periods plus 3 cycles after the `rxd` falling edge.
- `frame_err` is high for exactly one cycle, aligned with the failed stop sample.
- `busy` rises with the START entry and falls on return to IDLE.
- Back-to-back frames: a start edge arriving in the first IDLE cycle after STOP is accepted. No dead cycles are required beyond the stop bit.

## Test plan
- CLKS_PER_BIT=16. Send 0xA5 (line: start 0, bits 1,0,1,0,0,1,0,1, stop 1). Required: `rx_data`=0xA5, `rx_valid`=1 at bit-9.5 point, `frame_err`=0. Pulse `rx_ack`; `rx_valid` falls next cycle.
- Send 0x3C and 0xFF back-to-back with no `rx_ack`. Required: `rx_data`=0xFF, `rx_valid`=1, `rx_overrun`=1. One `rx_ack` clears both flags.
- Send 0x55 with the stop bit forced low, then hold the line low for 3 bit periods, then release it high. Required: one `frame_err` pulse, `rx_valid` stays 0, no further start detected until the line goes high; the next frame 0x12 is received correctly.
- Drive a 4-cycle low glitch on an idle line. Required: START aborts to IDLE, no `rx_valid`, no `frame_err`, `busy` returns low within CLKS_PER_BIT/2 + 3 cycles.
- Assert `rst` low during bit 4 of 0x81. Required: all outputs are 0 immediately; after release, the next frame 0x7E gives `rx_data`=0x7E with no error.
- Pulse `rx_ack` in the same cycle a second byte 0x99 completes while `rx_valid`=1. Required: `rx_data`=0x99, `rx_valid`=1, `rx_overrun`=0.
